pipe_regfile: RTL and testbench

PIPE_REGFILE -- requirements
Module: pipe_regfile

---
 rtl/pipe_regfile_if.sv | 36 +++
 rtl/pipe_regfile.sv | 79 +++++++
 tb/tb_pipe_regfile.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_regfile_if.sv
// pipe_regfile_if: read/writeback/claim bus of the pipelined register file.
//   master (issue/writeback side) drives rd_en, rd_addr, wr_*, claim_*;
//   slave (register file) drives rd_data, rd_busy, ps, init_done.
interface pipe_regfile_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int NUM_RD     = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0]                 rd_en;
    logic [NUM_RD-1:0][AW-1:0]         rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]                 rd_busy;
    logic                              ps;
    logic                              wr_valid;
    logic [AW-1:0]                     wr_addr;
    logic [DATA_WIDTH-1:0]             wr_data;
    logic                              wr_ps_en;
    logic                              wr_ps;
    logic                              claim_valid;
    logic [AW-1:0]                     claim_addr;
    logic                              init_done;

    modport master (
        output rd_en, rd_addr, wr_valid, wr_addr, wr_data, wr_ps_en, wr_ps,
               claim_valid, claim_addr,
        input  rd_data, rd_busy, ps, init_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, wr_ps_en, wr_ps,
               claim_valid, claim_addr,
        output rd_data, rd_busy, ps, init_done
    );
endinterface

// File: rtl/pipe_regfile.sv
// pipe_regfile: register file with per-register busy scoreboard, predicate bit
// and an INIT sweep that clears every register after reset.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : pipe_regfile_if.slave (read ports, writeback, claim, ps, init_done)
//   Define PIPE_REGFILE_BYPASS_EN to forward same-cycle writeback data to reads.
module pipe_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int NUM_RD     = 2
) (
    input logic            clk,
    input logic            rst,
    pipe_regfile_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam logic [AW:0]   NR   = (AW+1)'(NUM_REGS);
    localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                      state;
    logic [AW-1:0]               init_cnt;
    logic [DATA_WIDTH-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0]         busy;
    logic                        ps_q;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]           rd_busy;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NR;
    endfunction

    // Registers are not reset directly; the INIT sweep zeroes one per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
            busy     <= '0;
            ps_q     <= 1'b0;
        end else if (state == INIT) begin
            regs[init_cnt] <= '0;
            init_cnt       <= init_cnt + 1'b1;
            if (init_cnt == LAST)
                state <= RUN;
        end else begin
            if (bus.wr_valid && in_range(bus.wr_addr)) begin
                regs[bus.wr_addr] <= bus.wr_data;
                busy[bus.wr_addr] <= 1'b0;
            end
            // Placed after the writeback so a same-address claim leaves busy set.
            if (bus.claim_valid && in_range(bus.claim_addr))
                busy[bus.claim_addr] <= 1'b1;
            if (bus.wr_ps_en)
                ps_q <= bus.wr_ps;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (state == RUN && bus.rd_en[i] && in_range(bus.rd_addr[i])) begin
                rd_data[i] = regs[bus.rd_addr[i]];
                rd_busy[i] = busy[bus.rd_addr[i]];
`ifdef PIPE_REGFILE_BYPASS_EN
                if (bus.wr_valid && bus.wr_addr == bus.rd_addr[i]) begin
                    rd_data[i] = bus.wr_data;
                    rd_busy[i] = bus.claim_valid && bus.claim_addr == bus.rd_addr[i];
                end
`endif
            end
        end
    end

    assign bus.rd_data   = rd_data;
    assign bus.rd_busy   = rd_busy;
    assign bus.ps        = ps_q;
    assign bus.init_done = state == RUN;
endmodule

// File: tb/tb_pipe_regfile.sv
// tb_pipe_regfile: directed self-checking bench for pipe_regfile.
module tb_pipe_regfile;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pipe_regfile_if #(.DATA_WIDTH(8), .NUM_REGS(16), .NUM_RD(2)) bus ();

    pipe_regfile #(.DATA_WIDTH(8), .NUM_REGS(16), .NUM_RD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_valid    = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.wr_ps_en    = 1'b0;
        bus.wr_ps       = 1'b0;
        bus.claim_valid = 1'b0;
        bus.claim_addr  = '0;
    endtask

    // Holds INIT for 16 cycles while hammering it with writes/claims that must be ignored.
    task automatic init_phase(input string tag);
        for (int c = 0; c < 16; c++) begin
            bus.rd_en       = 2'b11;
            bus.rd_addr[0]  = 4'd7;
            bus.rd_addr[1]  = 4'(c);
            bus.wr_valid    = 1'b1;
            bus.wr_addr     = 4'(c);
            bus.wr_data     = 8'hFF;
            bus.claim_valid = 1'b1;
            bus.claim_addr  = 4'(c);
            bus.wr_ps_en    = 1'b1;
            bus.wr_ps       = 1'b1;
            #1;
            check({tag, "_init_done_low"}, bus.init_done, 0);
            check({tag, "_init_rd0"}, bus.rd_data[0], 0);
            check({tag, "_init_busy"}, bus.rd_busy, 0);
            check({tag, "_init_ps"}, bus.ps, 0);
            step();
        end
        idle();
        #1;
        check({tag, "_init_done_high"}, bus.init_done, 1);
    endtask

    initial begin
        rst = 1'b1;
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        idle();
        step();
        step();
        bus.rd_en = 2'b11;
        #1;
        check("rst_init_done", bus.init_done, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_busy", bus.rd_busy, 0);
        check("rst_ps", bus.ps, 0);
        rst = 1'b0;
        init_phase("first");

        for (int a = 0; a < 16; a++) begin
            bus.rd_en      = 2'b11;
            bus.rd_addr[0] = 4'(a);
            bus.rd_addr[1] = 4'(15 - a);
            #1;
            check("sweep_rd", bus.rd_data, 0);
            check("sweep_busy", bus.rd_busy, 0);
        end
        check("run_ps", bus.ps, 0);

        // write then read on both ports
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd3; bus.wr_data = 8'hA5;
        step();
        idle();
        bus.rd_addr[0] = 4'd3; bus.rd_addr[1] = 4'd3;
        #1;
        check("wr_r3_p0", bus.rd_data[0], 8'hA5);
        check("wr_r3_p1", bus.rd_data[1], 8'hA5);
        check("wr_r3_busy", bus.rd_busy, 0);
        bus.rd_en = 2'b01;
        #1;
        check("rd_en_off", bus.rd_data[1], 0);
        bus.rd_en = 2'b11;

        // scoreboard: claim r7, writeback two cycles later
        bus.claim_valid = 1'b1; bus.claim_addr = 4'd7;
        bus.rd_addr[0] = 4'd7; bus.rd_addr[1] = 4'd3;
        step();
        idle();
        #1;
        check("claim_busy_c1", bus.rd_busy[0], 1);
        check("claim_other_busy", bus.rd_busy[1], 0);
        step();
        check("claim_busy_c2", bus.rd_busy[0], 1);
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd7; bus.wr_data = 8'h3C;
        step();
        idle();
        #1;
        check("wb_busy_clr", bus.rd_busy[0], 0);
        check("wb_data", bus.rd_data[0], 8'h3C);

        // claim and write to the same register: claim wins
        bus.claim_valid = 1'b1; bus.claim_addr = 4'd5;
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd5; bus.wr_data = 8'h11;
        step();
        idle();
        bus.rd_addr[0] = 4'd5;
        #1;
        check("coll_data", bus.rd_data[0], 8'h11);
        check("coll_busy", bus.rd_busy[0], 1);

        // same-cycle write while reading
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'h10;
        step();
        bus.rd_addr[0] = 4'd2; bus.rd_addr[1] = 4'd2;
        bus.wr_data = 8'h77;
        #1;
`ifdef PIPE_REGFILE_BYPASS_EN
        check("byp_same_cycle", bus.rd_data[0], 8'h77);
`else
        check("byp_same_cycle", bus.rd_data[0], 8'h10);
`endif
        check("byp_busy", bus.rd_busy[0], 0);
        step();
        idle();
        #1;
        check("byp_next_p0", bus.rd_data[0], 8'h77);
        check("byp_next_p1", bus.rd_data[1], 8'h77);
        bus.wr_valid = 1'b1; bus.wr_addr = 4'd2; bus.wr_data = 8'h55;
        bus.claim_valid = 1'b1; bus.claim_addr = 4'd2;
        #1;
`ifdef PIPE_REGFILE_BYPASS_EN
        check("byp_claim_busy", bus.rd_busy[0], 1);
        check("byp_claim_data", bus.rd_data[0], 8'h55);
`else
        check("byp_claim_busy", bus.rd_busy[0], 0);
        check("byp_claim_data", bus.rd_data[0], 8'h77);
`endif
        step();
        idle();
        #1;
        check("claim_wr_after", bus.rd_busy[0], 1);

        // predicate register has no bypass
        bus.wr_ps_en = 1'b1; bus.wr_ps = 1'b1;
        #1;
        check("ps_no_bypass", bus.ps, 0);
        step();
        idle();
        check("ps_set", bus.ps, 1);
        bus.wr_ps_en = 1'b1; bus.wr_ps = 1'b0;
        step();
        idle();
        check("ps_clr", bus.ps, 0);
        bus.wr_ps_en = 1'b1; bus.wr_ps = 1'b1;
        step();
        idle();

        // reset in RUN, then again mid-INIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rerst_ps", bus.ps, 0);
        check("rerst_done", bus.init_done, 0);
        for (int c = 0; c < 8; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        init_phase("mid");
        bus.rd_en = 2'b11;
        bus.rd_addr[0] = 4'd7; bus.rd_addr[1] = 4'd5;
        #1;
        check("mid_r7_cleared", bus.rd_data[0], 0);
        check("mid_r5_cleared", bus.rd_data[1], 0);
        check("mid_busy_cleared", bus.rd_busy, 0);
        bus.rd_addr[0] = 4'd3; bus.rd_addr[1] = 4'd15;
        #1;
        check("mid_r3_cleared", bus.rd_data[0], 0);
        check("mid_r15_cleared", bus.rd_data[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
